// File: rtl/modulo_reconstruct_if.sv
`default_nettype none
// ============================================================================
// Module   : modulo_reconstruct_if
// Purpose  : Operand/result handshake bundle for modulo_reconstruct.
//            Carries the (q, b, r) operand triple with in_valid/in_ready and
//            the (a, overflow) result with out_valid/out_ready.
// Ports    : none (parameter WIDTH sets the operand/result width)
// Modports : master - producer/consumer side (drives operands, out_ready)
//            slave  - reconstruct unit side (drives in_ready and results)
// Revision : 1.0 - initial release
// ============================================================================
interface modulo_reconstruct_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] r;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] a;
  logic             overflow;

  modport master (
    output in_valid, q, b, r, out_ready,
    input  in_ready, out_valid, a, overflow
  );

  modport slave (
    input  in_valid, q, b, r, out_ready,
    output in_ready, out_valid, a, overflow
  );
endinterface
`default_nettype wire

// File: rtl/modulo_reconstruct.sv
`default_nettype none
// ============================================================================
// Module   : modulo_reconstruct
// Purpose  : Iterative shift-add unit rebuilding the dividend a = q*b + r
//            from quotient, divisor and remainder. One operation at a time.
// Ports    : clk  - clock, all state updates on rising edge
//            rst  - asynchronous active-high reset
//            bus  - modulo_reconstruct_if.slave (in_valid/in_ready, q, b, r,
//                   out_valid/out_ready, a, overflow)
// Config   : MODULO_RECONSTRUCT_EARLY_EXIT_EN - when defined, the multiply
//            loop stops as soon as the remaining multiplier bits are zero.
// Revision : 1.0 - initial release
// ============================================================================
module modulo_reconstruct #(
  parameter int WIDTH = 32
) (
  input  wire                 clk,
  input  wire                 rst,
  modulo_reconstruct_if.slave bus
);
  localparam int                 c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [WIDTH-1:0]       r_mplier;
  logic [2*WIDTH-1:0]     r_mcand;
  logic [2*WIDTH:0]       r_acc;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]       r_a;
  logic                   r_overflow;
  logic                   r_out_valid;

  logic                   w_accept;
  logic                   w_mul_last;
  logic [2*WIDTH:0]       w_acc_next;
  logic [WIDTH-1:0]       w_mplier_next;

  assign w_accept      = (r_state == S_IDLE) && bus.in_valid;
  assign w_acc_next    = r_mplier[0] ? (r_acc + {1'b0, r_mcand}) : r_acc;
  assign w_mplier_next = r_mplier >> 1;

  // The accumulator has one guard bit above 2*WIDTH so the final carry of
  // q*b + r is never lost; any set bit from WIDTH upward means overflow.
`ifdef MODULO_RECONSTRUCT_EARLY_EXIT_EN
  assign w_mul_last = (r_cnt == c_CNT_LAST) || (w_mplier_next == '0);
`else
  assign w_mul_last = (r_cnt == c_CNT_LAST);
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)      w_state_next = S_MUL;
      S_MUL:   if (w_mul_last)    w_state_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_next = S_IDLE;
      default:                    w_state_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mplier    <= '0;
      r_mcand     <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_a         <= '0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      // out_valid mirrors "state is DONE" but as a flop of its own
      r_out_valid <= (w_state_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mplier <= bus.q;
            r_mcand  <= {{WIDTH{1'b0}}, bus.b};
            r_acc    <= {{(WIDTH+1){1'b0}}, bus.r};
            r_cnt    <= '0;
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mplier <= w_mplier_next;
          r_mcand  <= r_mcand << 1;
          r_cnt    <= r_cnt + c_CNT_ONE;
          // Results are captured from the final partial sum directly so they
          // are valid in the same cycle out_valid rises.
          if (w_mul_last) begin
            r_a        <= w_acc_next[WIDTH-1:0];
            r_overflow <= |w_acc_next[2*WIDTH:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.a         = r_a;
  assign bus.overflow  = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_modulo_reconstruct.sv
`default_nettype none
// ============================================================================
// Module   : tb_modulo_reconstruct
// Purpose  : Self-checking bench for modulo_reconstruct. Expected results come
//            from full-precision arithmetic on the operand triple; expected
//            latency from the highest set bit of q (early-exit build) or WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
module tb_modulo_reconstruct;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  modulo_reconstruct_if #(.WIDTH(W)) bus_if ();

  modulo_reconstruct #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W:0] model_full(input logic [W-1:0] q,
                                              input logic [W-1:0] b,
                                              input logic [W-1:0] r);
    logic [2*W:0] fq, fb, fr;
    fq = {{(W+1){1'b0}}, q};
    fb = {{(W+1){1'b0}}, b};
    fr = {{(W+1){1'b0}}, r};
    return fq * fb + fr;
  endfunction

  function automatic int model_lat(input logic [W-1:0] q);
    int h;
    h = 0;
`ifdef MODULO_RECONSTRUCT_EARLY_EXIT_EN
    for (int i = 0; i < W; i++) if (q[i]) h = i + 1;
    if (h == 0) h = 1;
`else
    h = W;
`endif
    return h;
  endfunction

  // Called one time unit after a rising edge with the DUT idle; returns
  // aligned the same way, with the result released.
  task automatic run_op(input logic [W-1:0] q, input logic [W-1:0] b,
                        input logic [W-1:0] r, input string name);
    logic [2*W:0] full;
    logic [W-1:0] exp_a;
    logic         exp_ov;
    int           exp_lat;
    int           lat;
    full    = model_full(q, b, r);
    exp_a   = full[W-1:0];
    exp_ov  = |full[2*W:W];
    exp_lat = model_lat(q);
    bus_if.in_valid  = 1'b1;
    bus_if.q         = q;
    bus_if.b         = b;
    bus_if.r         = r;
    bus_if.out_ready = 1'b1;
    total++;
    if (bus_if.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s in_ready before accept: got %b want 1", name, bus_if.in_ready);
    end
    @(posedge clk); #1;
    // Operands must be ignored once accepted
    bus_if.in_valid = 1'b0;
    bus_if.q = $urandom;
    bus_if.b = $urandom;
    bus_if.r = $urandom;
    lat = 0;
    while (bus_if.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat != exp_lat) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    total++;
    if (bus_if.a !== exp_a || bus_if.overflow !== exp_ov) begin
      bad++;
      $display("FAIL %s result: got a=%h ov=%b want a=%h ov=%b",
               name, bus_if.a, bus_if.overflow, exp_a, exp_ov);
    end
    @(posedge clk); #1;
    total++;
    if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s release: got out_valid=%b in_ready=%b want 0/1",
               name, bus_if.out_valid, bus_if.in_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    bus_if.q = '0; bus_if.b = '0; bus_if.r = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0 ||
        bus_if.a !== '0 || bus_if.overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got in_ready=%b out_valid=%b a=%h ov=%b want 1/0/0/0",
               bus_if.in_ready, bus_if.out_valid, bus_if.a, bus_if.overflow);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    run_op(32'd7, 32'd10, 32'd3, "q7_b10_r3");
    run_op(32'd0, 32'd0, 32'hFFFF_FFFF, "zero_q_b");
    run_op(32'h0001_0000, 32'h0001_0000, 32'd0, "product_ovf");
    run_op(32'd1, 32'hFFFF_FFFF, 32'd1, "carry_ovf");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "all_ones");
  endtask

  task automatic test_random;
    logic [W-1:0] q;
    for (int i = 0; i < 20; i++) begin
      q = $urandom;
      // Mix of short and long multipliers to exercise varied latencies
      if (i % 3 == 0) q = q >> $urandom_range(W - 1, 0);
      run_op(q, $urandom, $urandom, "random");
    end
  endtask

  task automatic test_backpressure;
    int lat;
    bus_if.in_valid  = 1'b1;
    bus_if.q = 32'd3; bus_if.b = 32'd5; bus_if.r = 32'd2;
    bus_if.out_ready = 1'b0;
    @(posedge clk); #1;
    // Next triple held by the producer while the unit is busy
    bus_if.q = 32'd4; bus_if.b = 32'd4; bus_if.r = 32'd4;
    lat = 0;
    while (bus_if.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (bus_if.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_wait: got out_valid=%b want 1", bus_if.out_valid);
    end
    for (int c = 0; c < 5; c++) begin
      total++;
      if (bus_if.a !== 32'd17 || bus_if.overflow !== 1'b0 ||
          bus_if.out_valid !== 1'b1 || bus_if.in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cycle %0d: got a=%0d ov=%b out_valid=%b in_ready=%b want 17/0/1/0",
                 c, bus_if.a, bus_if.overflow, bus_if.out_valid, bus_if.in_ready);
      end
      @(posedge clk); #1;
    end
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: got out_valid=%b in_ready=%b want 0/1",
               bus_if.out_valid, bus_if.in_ready);
    end
    @(posedge clk); #1;
    total++;
    if (bus_if.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_next_accept: got in_ready=%b want 0", bus_if.in_ready);
    end
    bus_if.in_valid = 1'b0;
    lat = 0;
    while (bus_if.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (bus_if.out_valid !== 1'b1 || bus_if.a !== 32'd20 || lat != model_lat(32'd4)) begin
      bad++;
      $display("FAIL bp_next_result: got valid=%b a=%0d lat=%0d want 1/20/%0d",
               bus_if.out_valid, bus_if.a, lat, model_lat(32'd4));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int pulses;
    bus_if.in_valid  = 1'b1;
    bus_if.q = 32'hFFFF_FFFF; bus_if.b = 32'hFFFF_FFFF; bus_if.r = 32'd0;
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0 ||
        bus_if.a !== '0 || bus_if.overflow !== 1'b0) begin
      bad++;
      $display("FAIL midrst_assert: got in_ready=%b out_valid=%b a=%h ov=%b want 1/0/0/0",
               bus_if.in_ready, bus_if.out_valid, bus_if.a, bus_if.overflow);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus_if.out_valid === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    total++;
    if (pulses != 0 || bus_if.in_ready !== 1'b1 || bus_if.a !== '0) begin
      bad++;
      $display("FAIL midrst_after: got pulses=%0d in_ready=%b a=%h want 0/1/0",
               pulses, bus_if.in_ready, bus_if.a);
    end
    run_op(32'd2, 32'd2, 32'd1, "after_reset");
  endtask

  task automatic test_back_to_back;
    int t_first;
    int t_second;
    int cyc;
    logic prev;
    bus_if.in_valid  = 1'b1;
    bus_if.q = 32'h8000_0001; bus_if.b = 32'd3; bus_if.r = 32'd1;
    bus_if.out_ready = 1'b1;
    t_first = -1; t_second = -1; prev = 1'b0;
    for (cyc = 0; cyc < 120 && t_second < 0; cyc++) begin
      @(posedge clk); #1;
      if (bus_if.out_valid === 1'b1 && !prev) begin
        if (t_first < 0) t_first = cyc; else t_second = cyc;
      end
      prev = bus_if.out_valid;
    end
    bus_if.in_valid = 1'b0;
    total++;
    if (t_first < 0 || t_second < 0 || (t_second - t_first) != W + 2) begin
      bad++;
      $display("FAIL back_to_back period: got %0d want %0d", t_second - t_first, W + 2);
    end
    repeat (2 * W + 4) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
